// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: shift-add multiply or
// restoring divide over WIDTH iterations plus one sign-fix cycle; owns HI/LO.
//
// state | meaning
// IDLE  | waiting for StartE; MTHI/MTLO writes accepted
// CALC  | one multiply/divide iteration per edge, WIDTH edges total
// SIGN  | sign correction and HI/LO write-back, Done pulses next cycle
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             StartE,
   input  logic [1:0]       OpE,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic             HiLoWriteE,
   input  logic             HiLoSelE,
   input  logic [WIDTH-1:0] HiLoDataE,
   input  logic             FlushE,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q, acc_step, prod_fix;
   logic [WIDTH-1:0]   b_q, hi_q, lo_q, hi_res, lo_res;
   logic               is_div_q, neg_a_q, neg_b_q, done_q, dbz_q;
   logic               start_ok, finish, div_zero;
   logic               sign_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_trial, div_diff;

   assign start_ok = StartE & ~FlushE;
   assign finish   = (state_q == SIGN) & ~FlushE;
   assign div_zero = (b_q == '0);

   // Signed ops work on magnitudes; the sign flags are reapplied in SIGN.
   always_comb begin
      sign_op = ~OpE[0];
      a_neg   = sign_op & SrcAE[WIDTH-1];
      b_neg   = sign_op & SrcBE[WIDTH-1];
      a_mag   = a_neg ? (~SrcAE + WIDTH'(1)) : SrcAE;
      b_mag   = b_neg ? (~SrcBE + WIDTH'(1)) : SrcBE;
   end

   // acc holds {hi, lo}: multiplier/quotient shifts through lo, partial
   // product/remainder builds in hi.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_trial = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_trial - {1'b0, b_q};
      if (is_div_q) begin
         if (div_diff[WIDTH])
            acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         else
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= finish;
         dbz_q   <= finish & is_div_q & div_zero;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  cnt_q    <= '0;
                  acc_q    <= {{WIDTH{1'b0}}, a_mag};
                  b_q      <= b_mag;
                  is_div_q <= OpE[1];
                  neg_a_q  <= a_neg;
                  neg_b_q  <= b_neg;
               end
               if (HiLoWriteE) begin
                  if (HiLoSelE) hi_q <= HiLoDataE;
                  else          lo_q <= HiLoDataE;
               end
            end
            CALC: begin
               if (!FlushE) begin
                  acc_q <= acc_step;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            SIGN: begin
               if (finish) begin
                  hi_q <= hi_res;
                  lo_q <= lo_res;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = CALC;
         CALC: begin
            if (FlushE)             state_d = IDLE;
            else if (cnt_q == LAST) state_d = SIGN;
         end
         SIGN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Remainder with a zero divisor is the dividend magnitude, so the
   // dividend-sign fix restores SrcAE exactly; only LO needs overriding.
   always_comb begin
      Busy      = (state_q != IDLE);
      Done      = done_q;
      DivByZero = dbz_q;
      Hi        = hi_q;
      Lo        = lo_q;
      prod_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
      if (is_div_q) begin
         hi_res = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];
         if (div_zero)
            lo_res = '1;
         else if (neg_a_q ^ neg_b_q)
            lo_res = ~acc_q[WIDTH-1:0] + WIDTH'(1);
         else
            lo_res = acc_q[WIDTH-1:0];
      end else begin
         hi_res = prod_fix[2*WIDTH-1:WIDTH];
         lo_res = prod_fix[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO,
// a monitor pops and compares on every Done pulse.
module tb_muldiv_sequencer;

   localparam int W = 32;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   logic         clk = 1'b0;
   logic         rst_n, StartE, HiLoWriteE, HiLoSelE, FlushE;
   logic [1:0]   OpE;
   logic [W-1:0] SrcAE, SrcBE, HiLoDataE;
   logic         Busy, Done, DivByZero;
   logic [W-1:0] Hi, Lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0, bad = 0, done_cnt = 0, stray = 0, d0;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .StartE(StartE), .OpE(OpE),
      .SrcAE(SrcAE), .SrcBE(SrcBE), .HiLoWriteE(HiLoWriteE),
      .HiLoSelE(HiLoSelE), .HiLoDataE(HiLoDataE), .FlushE(FlushE),
      .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && DivByZero && !Done) stray++;
      if (rst_n && Done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(Done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("hi", Hi, mon_e.hi);
            check("lo", Lo, mon_e.lo);
            check("div_by_zero", 32'(DivByZero), 32'(mon_e.dbz));
         end
      end
   end

   // Called at cycle 0 (just after an edge); returns at cycle 34, or two
   // cycles later when not chained after checking the Done pulse width.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                         input bit chain);
      logic [W-1:0] hi0, lo0;
      bit busy_bad, hold_bad;
      exp_t e;
      busy_bad = 0;
      hold_bad = 0;
      hi0 = '0;
      lo0 = '0;
      e.hi = eh;
      e.lo = el;
      e.dbz = edz;
      OpE = op;
      SrcAE = a;
      SrcBE = b;
      StartE = 1'b1;
      sb.push_back(e);
      step(1);
      StartE = 1'b0;
      HiLoWriteE = 1'b0;
      for (int c = 1; c <= W + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            hi0 = Hi;
            lo0 = Lo;
         end
         if (Busy !== 1'b1 || Done !== 1'b0) busy_bad = 1;
         if (Hi !== hi0 || Lo !== lo0) hold_bad = 1;
         step(1);
      end
      check("busy_window", 32'(busy_bad), 32'd0);
      check("hilo_hold", 32'(hold_bad), 32'd0);
      if (!chain) begin
         @(negedge clk);
         check("done_busy_low", 32'(Busy), 32'd0);
         check("done_pulse", 32'(Done), 32'd1);
         step(1);
         @(negedge clk);
         check("done_single", 32'(Done), 32'd0);
         step(1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; StartE = 1'b0; OpE = 2'b00; SrcAE = '0; SrcBE = '0;
      HiLoWriteE = 1'b0; HiLoSelE = 1'b0; HiLoDataE = '0; FlushE = 1'b0;
      step(3);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_hi", Hi, 32'h0);
      check("reset_lo", Lo, 32'h0);
      check("reset_busy", 32'(Busy), 32'd0);
      check("reset_done", 32'(Done), 32'd0);
      step(1);

      HiLoWriteE = 1'b1; HiLoSelE = 1'b0; HiLoDataE = 32'h55;
      step(1);
      HiLoWriteE = 1'b0;
      @(negedge clk);
      check("mtlo", Lo, 32'h55);
      step(1);

      run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
      run_op(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
      run_op(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
      run_op(MULT,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_op(DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
      run_op(DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
      run_op(DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1'b1);
      run_op(DIVU,  32'd6,        32'd3,        32'd0,        32'd2,        1'b0, 1'b0);
      run_op(DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0);

      // MTLO in the issue cycle is later overwritten by the product
      HiLoWriteE = 1'b1; HiLoSelE = 1'b0; HiLoDataE = 32'h1234;
      run_op(MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);

      // flush: preload HI, issue, abort in cycle 10
      HiLoWriteE = 1'b1; HiLoSelE = 1'b1; HiLoDataE = 32'hAAAA;
      step(1);
      HiLoWriteE = 1'b0;
      d0 = done_cnt;
      OpE = MULTU; SrcAE = 32'd2; SrcBE = 32'd3; StartE = 1'b1;
      step(1);
      StartE = 1'b0;
      step(9);
      FlushE = 1'b1;
      @(negedge clk);
      check("flush_busy_c10", 32'(Busy), 32'd1);
      step(1);
      FlushE = 1'b0;
      @(negedge clk);
      check("flush_busy_c11", 32'(Busy), 32'd0);
      step(40);
      check("flush_no_done", 32'(done_cnt), 32'(d0));
      check("flush_hi", Hi, 32'hAAAA);
      check("flush_lo", Lo, 32'd6);

      // StartE and MTHI during Busy are both ignored
      begin
         exp_t e;
         e.hi = 32'd0; e.lo = 32'h100; e.dbz = 1'b0;
         sb.push_back(e);
      end
      OpE = MULTU; SrcAE = 32'h10; SrcBE = 32'h10; StartE = 1'b1;
      step(1);
      StartE = 1'b0;
      step(4);
      StartE = 1'b1; OpE = DIVU; SrcAE = 32'd9; SrcBE = 32'd3;
      HiLoWriteE = 1'b1; HiLoSelE = 1'b1; HiLoDataE = 32'hDEAD;
      step(1);
      StartE = 1'b0; HiLoWriteE = 1'b0;
      @(negedge clk);
      check("busy_mthi_ignored", Hi, 32'hAAAA);
      step(28);
      @(negedge clk);
      check("inject_done_c34", 32'(Done), 32'd1);
      step(1);
      @(negedge clk);
      check("inject_no_queue", 32'(Busy), 32'd0);
      step(1);

      // synchronous reset in cycle 20 of an operation
      d0 = done_cnt;
      OpE = MULTU; SrcAE = 32'hFFFFFFFF; SrcBE = 32'hFFFFFFFF; StartE = 1'b1;
      HiLoWriteE = 1'b1; HiLoSelE = 1'b1; HiLoDataE = 32'h77;
      step(1);
      StartE = 1'b0; HiLoWriteE = 1'b0;
      @(negedge clk);
      check("pre_reset_hi", Hi, 32'h77);
      step(19);
      rst_n = 1'b0;
      step(1);
      @(negedge clk);
      check("midreset_hi", Hi, 32'h0);
      check("midreset_lo", Lo, 32'h0);
      check("midreset_busy", 32'(Busy), 32'd0);
      check("midreset_done", 32'(Done), 32'd0);
      rst_n = 1'b1;
      step(40);
      check("midreset_no_done", 32'(done_cnt), 32'(d0));

      run_op(MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0, 1'b0);

      step(2);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      check("div_by_zero_stray", 32'(stray), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from EX and sequences a shift-add multiplier or restoring divider over WIDTH+1 cycles. It owns the HI/LO registers, which it updates once on completion. It reports Busy so the hazard logic can stall MFHI/MFLO and further mult/div issue.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- StartE  in  1  issue request from EX; sampled only in IDLE.
- OpE  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- SrcAE  in  WIDTH  multiplicand / dividend.
- SrcBE  in  WIDTH  multiplier / divisor.
- HiLoWriteE  in  1  MTHI/MTLO write strobe.
- HiLoSelE  in  1  1 = write HI, 0 = write LO.
- HiLoDataE  in  WIDTH  MTHI/MTLO data.
- FlushE  in  1  abort any in-flight operation (branch mispredict / exception).
- Busy  out  1  operation in flight; registered.
- Done  out  1  one-cycle pulse; HI/LO were just updated by an operation.
- DivByZero  out  1  pulses together with Done for DIV/DIVU with SrcBE = 0.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE:
  - On StartE=1 and FlushE=0, latch operands at the edge. Signed ops latch magnitudes plus result-sign flags.
  - Clear the iteration counter, go to CALC, set Busy=1.
- CALC:
  - One iteration per edge for exactly WIDTH edges, then go to SIGN.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per edge.
- SIGN (one edge):
  - Apply sign correction and write HI/LO.
  - Go to IDLE, set Busy=0, Done=1 for one cycle.
- Result rules:
  - Multiply: {HI,LO} = full 2*WIDTH product. Signed product is negated when operand signs differ.
  - Divide: LO = quotient, HI = remainder.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV of 0x80000000 by -1 gives LO=0x80000000, HI=0.
  - Divide by zero (DIV or DIVU): LO = all ones, HI = SrcAE as issued (unmodified), DivByZero=1 with Done. No exception is raised.
- HiLoWriteE: honoured only in IDLE; updates the selected register at the edge. Ignored while Busy.
- StartE while Busy: ignored; no queueing.
- StartE and HiLoWriteE in the same IDLE cycle: both take effect. The MTHI/MTLO value is later overwritten by the operation result.
- FlushE:
  - In CALC or SIGN: go to IDLE at the next edge with Busy=0.
  - No Done and no DivByZero. HI/LO keep their pre-operation values.
  - In IDLE: suppresses StartE.
- Reset (rst_n=0 at an edge), from any state including mid-operation: state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, counter=0.

## Timing
- Cycle numbering: cycle 0 is the cycle StartE is presented; it is sampled at the end of cycle 0.
- Busy is high in cycles 1 .. WIDTH+1. For WIDTH=32 that is cycles 1–33.
- Done and DivByZero are high in cycle WIDTH+2 only (cycle 34 for WIDTH=32).
- Hi/Lo hold the new result from cycle WIDTH+2 onward and do not change in cycles 1 .. WIDTH+1.
- Earliest back-to-back issue: StartE in cycle WIDTH+2, which is also the Done cycle.
- Done, DivByZero and Busy are registered outputs; there is no combinational path from inputs to outputs.
- A flush in cycle k (1 ≤ k ≤ WIDTH+1) gives Busy=0 from cycle k+1.
- Hi/Lo are directly readable every cycle. MFHI/MFLO correctness relies on the hazard unit stalling while Busy=1.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Busy high cycles 1–33; Done pulse in cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, DivByZero=1 only in cycle 34. A following DIVU 6/3 -> DivByZero stays 0.
- Preload HI=0xAAAA via MTHI, issue MULTU 2×3, FlushE in cycle 10 -> Busy=0 in cycle 11, no Done, HI=0xAAAA and LO unchanged.
- Mid-operation stimulus:
  - StartE and HiLoWriteE during Busy -> both ignored; the result matches the original operation.
  - rst_n=0 in cycle 20 -> next cycle Hi=Lo=0, Busy=0, Done=0.
